ama_riscv_mem_wb_stage: RTL and testbench
=========================================

Name: ama_riscv_mem_wb_stage

Overview:
- MEM/WB stage of the AMA-RISCV 5-stage core. It consumes the EX/MEM pipeline registers and the synchronous DMEM read data.
- Performs load shift/mask, the writeback select mux and the tohost CSR, and registers the MEM/WB pipeline stage.
- Its outputs drive the register file write port and the writeback forwarding path into ID/EX.

Parameters:
- TOHOST_ADDR, 12'h51E, CSR address decoded as tohost
- RST_PC, 32'h0, reset value of pc_wb

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- clear_mem  in  1  flush MEM/WB register; suppresses CSR write and counters this cycle
- pc_mem  in  32  PC of instruction in MEM
- alu_out_mem  in  32  ALU result (EX/MEM)
- dmem_read_data_mem  in  32  DMEM dout, valid in MEM cycle
- load_sm_offset_mem  in  2  byte offset of load address
- inst_mem  in  32  instruction in MEM (32'h0 = bubble)
- load_sm_en_mem  in  1  load shift/mask enable
- wb_sel_mem  in  2  0=DMEM, 1=ALU, 2=PC+4, 3=CSR
- rd_addr_mem  in  5  destination register
- reg_we_mem  in  1  register write enable
- csr_din_mem  in  32  rs1 value for CSRRW
- writeback  out  32  combinational writeback data (to reg file data_d)
- reg_we_out  out  1  reg file write enable, forced 0 when rd==0
- rd_addr_out  out  5  reg file addr_d
- writeback_wb  out  32  registered writeback (MEM/WB)
- rd_addr_wb  out  5  registered rd
- reg_we_wb  out  1  registered reg_we_out
- inst_wb  out  32  registered inst_mem
- pc_wb  out  32  registered pc_mem
- tohost  out  32  tohost CSR value

Behaviour:
- Reset (rst sampled high at posedge): writeback_wb=0, rd_addr_wb=0, reg_we_wb=0, inst_wb=0, pc_wb=RST_PC, tohost=0.
- Reset mid-operation overrides clear_mem and any CSR write.
- Load unit (combinational):
  - funct3 = inst_mem[14:12]. When load_sm_en_mem=0, output = dmem_read_data_mem unchanged.
  - LB(000): byte[offset], sign-extended. LBU(100): zero-extended.
  - LH(001)/LHU(101): halfword at offset[1] (offset[0] ignored), sign-/zero-extended.
  - LW(010): word, offset ignored.
  - Other funct3: pass the word through.
- Writeback mux:
  - sel0 = load unit output; sel1 = alu_out_mem; sel2 = pc_mem+4 (mod 2^32); sel3 = tohost (old value, read-before-write).
- Write-port outputs: reg_we_out = reg_we_mem & (rd_addr_mem!=0); rd_addr_out = rd_addr_mem. All three are zero-latency.
- CSR write:
  - Condition: opcode inst_mem[6:0]=1110011, inst_mem[31:20]=TOHOST_ADDR, not clear_mem.
  - CSRRW(001): tohost <= csr_din_mem. CSRRWI(101): tohost <= {27'b0, inst_mem[19:15]}.
  - The new value is visible the cycle after. An instruction reading tohost in the same cycle gets the old value.
- MEM/WB register:
  - 1-cycle latency; clear_mem loads reset values (pc_wb <= RST_PC).
  - Otherwise it captures writeback, rd_addr_out, reg_we_out, inst_mem, pc_mem.
- No stall input: the stage never stalls, it is only flushed.

Optional Feature:
- Macro AMA_RISCV_PERF_CNT_EN.
- When defined, adds two outputs: cycle_cnt (out 64) and instret_cnt (out 64).
  - Both reset to 0.
  - cycle_cnt increments every non-reset cycle.
  - instret_cnt increments when inst_mem != 32'h0 and clear_mem=0.
  - Both wrap modulo 2^64. A simultaneous reset wins.
- When undefined, the ports and counters are absent. Behaviour is otherwise identical.

Test Plan:
- Reset → rst=1 for 2 cycles, all inputs random → all registered outputs 0, pc_wb=0, tohost=0, reg_we_out follows inputs combinationally.
- Loads → dmem=32'h8081_F2F3, load_sm_en=1, wb_sel=0, expected writeback:
  - LB offset1 → 32'hFFFF_FFF2
  - LBU offset3 → 32'h0000_0080
  - LH offset2 → 32'hFFFF_8081
  - LHU offset0 → 32'h0000_F2F3
  - LW → 32'h8081_F2F3
- Writeback select / x0 → wb_sel=2, pc_mem=32'hFFFF_FFFC → writeback=0. rd=0 with reg_we=1 → reg_we_out=0, reg_we_wb=0 next cycle.
- CSR → CSRRW 0x51E with csr_din=32'h1, wb_sel=3, tohost=0:
  - writeback=0 in that cycle; tohost=1 next cycle.
  - CSRRWI imm=5 → tohost=5.
  - The same CSRRW with clear_mem=1 → tohost unchanged.
- Flush → clear_mem=1 with valid ALU instruction (rd=7, alu_out=32'hDEAD_BEEF) → next cycle reg_we_wb=0, rd_addr_wb=0, inst_wb=0; writeback still shows 32'hDEAD_BEEF combinationally.
- Counters (macro defined):
  - 10 cycles after reset, inst_mem non-zero for 6 (1 of which flushed) and 0 for 4 → cycle_cnt=10, instret_cnt=5.
  - Preload cycle_cnt near 2^64-1 via force → wraps to 0.

Source files
------------

// File: rtl/ama_riscv_mem_wb_stage_if.sv
// ----------------------------------------------------------------------------
// ama_riscv_mem_wb_stage_if
//   Bundle of EX/MEM inputs and MEM/WB outputs of the MEM/WB stage.
//   master : EX/MEM side (drives pipeline inputs, observes writeback outputs)
//   slave  : the MEM/WB stage itself
//   Inputs : clear_mem, pc_mem, alu_out_mem, dmem_read_data_mem,
//            load_sm_offset_mem, inst_mem, load_sm_en_mem, wb_sel_mem,
//            rd_addr_mem, reg_we_mem, csr_din_mem
//   Outputs: writeback, reg_we_out, rd_addr_out (zero latency),
//            writeback_wb, rd_addr_wb, reg_we_wb, inst_wb, pc_wb (registered),
//            tohost
// ----------------------------------------------------------------------------
interface ama_riscv_mem_wb_stage_if;
  logic        clear_mem;
  logic [31:0] pc_mem;
  logic [31:0] alu_out_mem;
  logic [31:0] dmem_read_data_mem;
  logic [1:0]  load_sm_offset_mem;
  logic [31:0] inst_mem;
  logic        load_sm_en_mem;
  logic [1:0]  wb_sel_mem;
  logic [4:0]  rd_addr_mem;
  logic        reg_we_mem;
  logic [31:0] csr_din_mem;

  logic [31:0] writeback;
  logic        reg_we_out;
  logic [4:0]  rd_addr_out;
  logic [31:0] writeback_wb;
  logic [4:0]  rd_addr_wb;
  logic        reg_we_wb;
  logic [31:0] inst_wb;
  logic [31:0] pc_wb;
  logic [31:0] tohost;

  modport master (
    output clear_mem, pc_mem, alu_out_mem, dmem_read_data_mem, load_sm_offset_mem,
           inst_mem, load_sm_en_mem, wb_sel_mem, rd_addr_mem, reg_we_mem, csr_din_mem,
    input  writeback, reg_we_out, rd_addr_out, writeback_wb, rd_addr_wb, reg_we_wb,
           inst_wb, pc_wb, tohost
  );

  modport slave (
    input  clear_mem, pc_mem, alu_out_mem, dmem_read_data_mem, load_sm_offset_mem,
           inst_mem, load_sm_en_mem, wb_sel_mem, rd_addr_mem, reg_we_mem, csr_din_mem,
    output writeback, reg_we_out, rd_addr_out, writeback_wb, rd_addr_wb, reg_we_wb,
           inst_wb, pc_wb, tohost
  );
endinterface

// File: rtl/ama_riscv_mem_wb_stage.sv
// ----------------------------------------------------------------------------
// ama_riscv_mem_wb_stage
//   MEM/WB stage of the AMA-RISCV 5-stage core: load shift/mask, writeback
//   select mux, tohost CSR and the MEM/WB pipeline register.
//   Ports:
//     clk, rst  : core clock, synchronous active-high reset
//     mem_wb    : ama_riscv_mem_wb_stage_if.slave (EX/MEM in, writeback out)
//     cycle_cnt, instret_cnt : 64-bit perf counters (only with
//                              AMA_RISCV_PERF_CNT_EN defined)
//   Optional feature macro: AMA_RISCV_PERF_CNT_EN
//   The stage never stalls; clear_mem flushes the MEM/WB register and blocks
//   the CSR write and the retired-instruction count for that cycle.
// ----------------------------------------------------------------------------
module ama_riscv_mem_wb_stage #(
  parameter logic [11:0] TOHOST_ADDR = 12'h51E,
  parameter logic [31:0] RST_PC      = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  ama_riscv_mem_wb_stage_if.slave  mem_wb
`ifdef AMA_RISCV_PERF_CNT_EN
  ,
  output logic [63:0]              cycle_cnt,
  output logic [63:0]              instret_cnt
`endif
);

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  logic [2:0]  funct3;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] pc_plus4;
  logic [31:0] wb_data;
  logic        reg_we;
  logic        csr_hit;

  logic [31:0] writeback_wb_q, writeback_wb_d;
  logic [4:0]  rd_addr_wb_q,   rd_addr_wb_d;
  logic        reg_we_wb_q,    reg_we_wb_d;
  logic [31:0] inst_wb_q,      inst_wb_d;
  logic [31:0] pc_wb_q,        pc_wb_d;
  logic [31:0] tohost_q,       tohost_d;

  assign funct3 = mem_wb.inst_mem[14:12];

  // Byte lane picked by the full offset; halfword only by offset[1].
  always_comb begin
    ld_byte = mem_wb.dmem_read_data_mem[7:0];
    case (mem_wb.load_sm_offset_mem)
      2'd1:    ld_byte = mem_wb.dmem_read_data_mem[15:8];
      2'd2:    ld_byte = mem_wb.dmem_read_data_mem[23:16];
      2'd3:    ld_byte = mem_wb.dmem_read_data_mem[31:24];
      default: ld_byte = mem_wb.dmem_read_data_mem[7:0];
    endcase
  end

  assign ld_half = mem_wb.load_sm_offset_mem[1] ? mem_wb.dmem_read_data_mem[31:16]
                                                : mem_wb.dmem_read_data_mem[15:0];

  always_comb begin
    load_data = mem_wb.dmem_read_data_mem;
    if (mem_wb.load_sm_en_mem) begin
      case (funct3)
        3'b000:  load_data = {{24{ld_byte[7]}}, ld_byte};
        3'b100:  load_data = {24'h0, ld_byte};
        3'b001:  load_data = {{16{ld_half[15]}}, ld_half};
        3'b101:  load_data = {16'h0, ld_half};
        default: load_data = mem_wb.dmem_read_data_mem;
      endcase
    end
  end

  assign pc_plus4 = mem_wb.pc_mem + 32'd4;

  // CSR source reads the registered tohost, so a same-cycle CSR write is
  // not observed (read-before-write).
  always_comb begin
    wb_data = load_data;
    case (mem_wb.wb_sel_mem)
      2'd0:    wb_data = load_data;
      2'd1:    wb_data = mem_wb.alu_out_mem;
      2'd2:    wb_data = pc_plus4;
      default: wb_data = tohost_q;
    endcase
  end

  assign reg_we = mem_wb.reg_we_mem & (mem_wb.rd_addr_mem != 5'd0);

  assign mem_wb.writeback   = wb_data;
  assign mem_wb.reg_we_out  = reg_we;
  assign mem_wb.rd_addr_out = mem_wb.rd_addr_mem;

  assign csr_hit = (mem_wb.inst_mem[6:0] == OPC_SYSTEM) &&
                   (mem_wb.inst_mem[31:20] == TOHOST_ADDR) &&
                   !mem_wb.clear_mem;

  always_comb begin
    tohost_d = tohost_q;
    if (csr_hit) begin
      case (funct3)
        3'b001:  tohost_d = mem_wb.csr_din_mem;
        3'b101:  tohost_d = {27'h0, mem_wb.inst_mem[19:15]};
        default: tohost_d = tohost_q;
      endcase
    end
  end

  always_comb begin
    writeback_wb_d = wb_data;
    rd_addr_wb_d   = mem_wb.rd_addr_mem;
    reg_we_wb_d    = reg_we;
    inst_wb_d      = mem_wb.inst_mem;
    pc_wb_d        = mem_wb.pc_mem;
    if (mem_wb.clear_mem) begin
      writeback_wb_d = 32'h0;
      rd_addr_wb_d   = 5'd0;
      reg_we_wb_d    = 1'b0;
      inst_wb_d      = 32'h0;
      pc_wb_d        = RST_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      writeback_wb_q <= 32'h0;
      rd_addr_wb_q   <= 5'd0;
      reg_we_wb_q    <= 1'b0;
      inst_wb_q      <= 32'h0;
      pc_wb_q        <= RST_PC;
      tohost_q       <= 32'h0;
    end else begin
      writeback_wb_q <= writeback_wb_d;
      rd_addr_wb_q   <= rd_addr_wb_d;
      reg_we_wb_q    <= reg_we_wb_d;
      inst_wb_q      <= inst_wb_d;
      pc_wb_q        <= pc_wb_d;
      tohost_q       <= tohost_d;
    end
  end

  assign mem_wb.writeback_wb = writeback_wb_q;
  assign mem_wb.rd_addr_wb   = rd_addr_wb_q;
  assign mem_wb.reg_we_wb    = reg_we_wb_q;
  assign mem_wb.inst_wb      = inst_wb_q;
  assign mem_wb.pc_wb        = pc_wb_q;
  assign mem_wb.tohost       = tohost_q;

`ifdef AMA_RISCV_PERF_CNT_EN
  logic [63:0] cycle_cnt_q,   cycle_cnt_d;
  logic [63:0] instret_cnt_q, instret_cnt_d;

  // A zero instruction word is a bubble and does not retire.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + 64'd1;
    instret_cnt_d = instret_cnt_q;
    if ((mem_wb.inst_mem != 32'h0) && !mem_wb.clear_mem)
      instret_cnt_d = instret_cnt_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= 64'h0;
      instret_cnt_q <= 64'h0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_ama_riscv_mem_wb_stage.sv
// ----------------------------------------------------------------------------
// tb_ama_riscv_mem_wb_stage
//   Self-checking bench. Combinational outputs are compared inline right after
//   the inputs are driven; registered outputs are pushed as expectations into
//   a queue and popped by a monitor one clock later.
// ----------------------------------------------------------------------------
module tb_ama_riscv_mem_wb_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ama_riscv_mem_wb_stage_if bus();

`ifdef AMA_RISCV_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  ama_riscv_mem_wb_stage #(
    .TOHOST_ADDR (12'h51E),
    .RST_PC      (32'h0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_wb      (bus)
`ifdef AMA_RISCV_PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_th = 32'h0;

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] th;
    string       name;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] INST_ALU = {7'b0, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011};
  localparam logic [31:0] INST_RW  = {12'h51E, 5'd1, 3'b001, 5'd3, 7'b1110011};
  localparam logic [31:0] INST_RWI = {12'h51E, 5'd5, 3'b101, 5'd3, 7'b1110011};

  // Registered-output scoreboard: every push made before a posedge is
  // consumed right after that posedge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({bus.writeback_wb, bus.rd_addr_wb, bus.reg_we_wb, bus.inst_wb, bus.pc_wb, bus.tohost}
          !== {e.wb, e.rd, e.we, e.inst, e.pc, e.th}) begin
        n_fail++;
        $display("FAIL %s: got wb=%h rd=%0d we=%b inst=%h pc=%h tohost=%h, want wb=%h rd=%0d we=%b inst=%h pc=%h tohost=%h",
                 e.name, bus.writeback_wb, bus.rd_addr_wb, bus.reg_we_wb, bus.inst_wb, bus.pc_wb,
                 bus.tohost, e.wb, e.rd, e.we, e.inst, e.pc, e.th);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic clr, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] dmem, input logic [1:0] off, input logic [31:0] inst,
                       input logic lsm, input logic [1:0] sel, input logic [4:0] rd,
                       input logic we, input logic [31:0] csr);
    @(negedge clk);
    bus.clear_mem          = clr;
    bus.pc_mem             = pc;
    bus.alu_out_mem        = alu;
    bus.dmem_read_data_mem = dmem;
    bus.load_sm_offset_mem = off;
    bus.inst_mem           = inst;
    bus.load_sm_en_mem     = lsm;
    bus.wb_sel_mem         = sel;
    bus.rd_addr_mem        = rd;
    bus.reg_we_mem         = we;
    bus.csr_din_mem        = csr;
    #1;
  endtask

  task automatic push(input logic [31:0] wb, input logic [4:0] rd, input logic we,
                      input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] th,
                      input string name);
    exp_t e;
    e.wb = wb; e.rd = rd; e.we = we; e.inst = inst; e.pc = pc; e.th = th; e.name = name;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    logic exp_we;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom_range(0, 3),
            (i == 0) ? INST_RW : $urandom, $urandom_range(0, 1), $urandom_range(0, 3),
            $urandom_range(0, 31), $urandom_range(0, 1), $urandom);
      exp_we = bus.reg_we_mem & (bus.rd_addr_mem != 5'd0);
      n_checks++;
      if ({bus.reg_we_out, bus.rd_addr_out} !== {exp_we, bus.rd_addr_mem}) begin
        n_fail++;
        $display("FAIL reset_we_comb: got we=%b rd=%0d want we=%b rd=%0d",
                 bus.reg_we_out, bus.rd_addr_out, exp_we, bus.rd_addr_mem);
      end
      push(32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, "reset_regs");
    end
    // Release reset with a bubble on the inputs.
    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b0, 2'd0, 5'd0, 1'b0, 32'h0);
    rst = 1'b0;
    exp_th = 32'h0;
    push(32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, "reset_release");
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [1:0]  off [6] = '{2'd1,   2'd3,   2'd2,   2'd0,   2'd3,   2'd1};
    logic        en  [6] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
    logic [31:0] exp [6] = '{32'hFFFF_FFF2, 32'h0000_0080, 32'hFFFF_8081,
                             32'h0000_F2F3, 32'h8081_F2F3, 32'h8081_F2F3};
    logic [31:0] inst;
    for (int i = 0; i < 6; i++) begin
      inst = {12'h0, 5'd1, f3[i], 5'd3, 7'b0000011};
      drive(1'b0, 32'h100 + i * 4, 32'h5555_5555, 32'h8081_F2F3, off[i], inst, en[i],
            2'd0, 5'd3, 1'b1, 32'h0);
      n_checks++;
      if (bus.writeback !== exp[i]) begin
        n_fail++;
        $display("FAIL load_%0d: got %h want %h", i, bus.writeback, exp[i]);
      end
      push(exp[i], 5'd3, 1'b1, inst, 32'h100 + i * 4, exp_th, "load_reg");
    end
  endtask

  task automatic test_wb_sel();
    drive(1'b0, 32'hFFFF_FFFC, 32'h1111_1111, 32'h2222_2222, 2'd0, INST_ALU, 1'b0,
          2'd2, 5'd9, 1'b1, 32'h0);
    n_checks++;
    if (bus.writeback !== 32'h0) begin
      n_fail++;
      $display("FAIL pc4_wrap: got %h want %h", bus.writeback, 32'h0);
    end
    push(32'h0, 5'd9, 1'b1, INST_ALU, 32'hFFFF_FFFC, exp_th, "pc4_reg");

    drive(1'b0, 32'h300, 32'h1234_5678, 32'h0, 2'd0, INST_ALU, 1'b0, 2'd1, 5'd0, 1'b1, 32'h0);
    n_checks++;
    if ({bus.writeback, bus.reg_we_out, bus.rd_addr_out} !== {32'h1234_5678, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL x0_write: got wb=%h we=%b rd=%0d want wb=12345678 we=0 rd=0",
               bus.writeback, bus.reg_we_out, bus.rd_addr_out);
    end
    push(32'h1234_5678, 5'd0, 1'b0, INST_ALU, 32'h300, exp_th, "x0_reg");
  endtask

  task automatic test_csr();
    drive(1'b0, 32'h400, 32'h0, 32'h0, 2'd0, INST_RW, 1'b0, 2'd3, 5'd4, 1'b1, 32'h1);
    n_checks++;
    if (bus.writeback !== 32'h0) begin
      n_fail++;
      $display("FAIL csrrw_old: got %h want %h", bus.writeback, 32'h0);
    end
    exp_th = 32'h1;
    push(32'h0, 5'd4, 1'b1, INST_RW, 32'h400, exp_th, "csrrw_reg");

    drive(1'b0, 32'h404, 32'h0, 32'h0, 2'd0, INST_RWI, 1'b0, 2'd3, 5'd4, 1'b1, 32'hFFFF_FFFF);
    n_checks++;
    if (bus.writeback !== 32'h1) begin
      n_fail++;
      $display("FAIL csrrwi_old: got %h want %h", bus.writeback, 32'h1);
    end
    exp_th = 32'h5;
    push(32'h1, 5'd4, 1'b1, INST_RWI, 32'h404, exp_th, "csrrwi_reg");

    drive(1'b1, 32'h408, 32'h0, 32'h0, 2'd0, INST_RW, 1'b0, 2'd3, 5'd4, 1'b1, 32'h1);
    n_checks++;
    if (bus.writeback !== 32'h5) begin
      n_fail++;
      $display("FAIL csr_flushed_read: got %h want %h", bus.writeback, 32'h5);
    end
    push(32'h0, 5'd0, 1'b0, 32'h0, 32'h0, exp_th, "csr_flushed_reg");

    drive(1'b0, 32'h40C, 32'h0, 32'h0, 2'd0, INST_ALU, 1'b0, 2'd3, 5'd6, 1'b1, 32'h0);
    n_checks++;
    if (bus.writeback !== 32'h5) begin
      n_fail++;
      $display("FAIL csr_read: got %h want %h", bus.writeback, 32'h5);
    end
    push(32'h5, 5'd6, 1'b1, INST_ALU, 32'h40C, exp_th, "csr_read_reg");
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h500, 32'hDEAD_BEEF, 32'h0, 2'd0, INST_ALU, 1'b0, 2'd1, 5'd7, 1'b1, 32'h0);
    n_checks++;
    if ({bus.writeback, bus.reg_we_out} !== {32'hDEAD_BEEF, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_comb: got wb=%h we=%b want wb=deadbeef we=1",
               bus.writeback, bus.reg_we_out);
    end
    push(32'h0, 5'd0, 1'b0, 32'h0, 32'h0, exp_th, "flush_reg");
  endtask

  task automatic test_back_to_back();
    logic [31:0] alu, pc;
    logic [4:0]  rd;
    logic        we;
    for (int i = 0; i < 8; i++) begin
      alu = $urandom;
      pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      rd  = $urandom_range(0, 31);
      we  = $urandom_range(0, 1);
      drive(1'b0, pc, alu, $urandom, $urandom_range(0, 3), INST_ALU, 1'b1, 2'd1, rd, we, $urandom);
      n_checks++;
      if (bus.writeback !== alu) begin
        n_fail++;
        $display("FAIL b2b_%0d: got %h want %h", i, bus.writeback, alu);
      end
      push(alu, rd, we && (rd != 5'd0), INST_ALU, pc, exp_th, "b2b_reg");
    end
  endtask

`ifdef AMA_RISCV_PERF_CNT_EN
  task automatic test_counters();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b0, 2'd0, 5'd0, 1'b0, 32'h0);
    rst = 1'b1;
    exp_th = 32'h0;
    push(32'h0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, "cnt_reset");
    for (int i = 0; i < 10; i++) begin
      drive(i == 2, 32'h600 + i * 4, 32'h0, 32'h0, 2'd0, (i < 6) ? INST_ALU : 32'h0,
            1'b0, 2'd1, 5'd0, 1'b0, 32'h0);
      if (i == 0) rst = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if ({cycle_cnt, instret_cnt} !== {64'd10, 64'd5}) begin
      n_fail++;
      $display("FAIL counters: got cycle=%0d instret=%0d want cycle=10 instret=5",
               cycle_cnt, instret_cnt);
    end
    force dut.cycle_cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cycle_cnt_q;
    @(negedge clk);
    n_checks++;
    if (cycle_cnt !== 64'h0) begin
      n_fail++;
      $display("FAIL cycle_wrap: got %h want %h", cycle_cnt, 64'h0);
    end
  endtask
`endif

  initial begin
    bus.clear_mem = 1'b0; bus.pc_mem = 32'h0; bus.alu_out_mem = 32'h0;
    bus.dmem_read_data_mem = 32'h0; bus.load_sm_offset_mem = 2'd0; bus.inst_mem = 32'h0;
    bus.load_sm_en_mem = 1'b0; bus.wb_sel_mem = 2'd0; bus.rd_addr_mem = 5'd0;
    bus.reg_we_mem = 1'b0; bus.csr_din_mem = 32'h0;

    test_reset();
    test_loads();
    test_wb_sel();
    test_csr();
    test_flush();
    test_back_to_back();
`ifdef AMA_RISCV_PERF_CNT_EN
    test_counters();
`endif
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
